// File: rtl/axi_line_fill_pkg.sv
// -----------------------------------------------------------------------------
// axi_line_fill_pkg
// Shared cache definitions: AXI4 encodings used by the line-fill engine, the
// default line geometry, the line-fill FSM state enum and the cache's own
// READY/REPLACE state encoding.
// -----------------------------------------------------------------------------
package axi_line_fill_pkg;

  // Default words per cache line (32 x 32-bit words = 128-byte line)
  localparam int FILL_LINE_WORDS = 32;

  // AXI4 encodings
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Line-fill engine states
  typedef enum logic [2:0] {
    FILL_IDLE  = 3'd0,
    FILL_ADDR  = 3'd1,
    FILL_DATA  = 3'd2,
    FILL_LAST  = 3'd3,
    FILL_DRAIN = 3'd4
  } fill_state_e;

  // Cache controller states (the fill engine sees REPLACE as the miss level)
  typedef enum logic {
    CACHE_READY   = 1'b0,
    CACHE_REPLACE = 1'b1
  } cache_state_e;

endpackage

// File: rtl/axi_line_fill.sv
// -----------------------------------------------------------------------------
// axi_line_fill
// Fetches one cache line over an AXI4 INCR read burst when the cache signals a
// miss, and streams the returned words into the cache data RAM one at a time.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   miss, miss_addr       miss level from the cache and the missing CPU address
//   mem_addr/mem_data_in  byte address and word written into the cache
//   mem_wstb              byte strobes for the cache write (always all ones)
//   mem_data_valid        one-cycle pulse per delivered word
//   mem_last              one-cycle pulse the cycle after the final word
//   ar*                   AXI4 read-address channel (master side)
//   r*                    AXI4 read-data channel (master side)
//   fill_err              sticky error flag for the current/last fill
// -----------------------------------------------------------------------------
module axi_line_fill
  import axi_line_fill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = FILL_LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [3:0]        mem_wstb,
  output logic              mem_data_valid,
  output logic              mem_last,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              fill_err
);

  localparam int CNT_W    = $clog2(LINE_WORDS);
  // Byte-offset bits inside a line: 7 for a 128-byte line
  localparam int LINE_LG2 = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  fill_state_e       state;
  fill_state_e       state_nxt;
  logic [ADDR_W-1:0] line_base;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] beat_ofs;
  logic              beat;
  logic              final_beat;

  assign beat       = rvalid && rready;
  assign final_beat = (count == LAST_BEAT);
  assign beat_ofs   = ADDR_W'({count, 2'b00});

  // AR payload is a pure function of the latched line base, so it is
  // naturally stable for as long as arvalid waits on arready.
  assign araddr   = line_base;
  assign arlen    = 8'(LINE_WORDS - 1);
  assign arsize   = AXI_SIZE_4B;
  assign arburst  = AXI_BURST_INCR;
  assign mem_wstb = 4'b1111;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    unique case (state)
      FILL_IDLE: begin
        if (miss) state_nxt = FILL_ADDR;
      end
      FILL_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = FILL_DATA;
      end
      FILL_DATA: begin
        // Refusing a beat while the previous word is being written keeps the
        // cache write port to at most one word every other cycle.
        rready = !mem_data_valid;
        if (rvalid && rready && final_beat) state_nxt = FILL_LAST;
      end
      FILL_LAST: begin
        state_nxt = FILL_DRAIN;
      end
      FILL_DRAIN: begin
        // Wait for the cache to drop miss so its stale level cannot
        // immediately launch a second fill of the same line.
        if (!miss) state_nxt = FILL_IDLE;
      end
      default: begin
        state_nxt = FILL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_base      <= '0;
      count          <= '0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_data_valid <= 1'b0;
      mem_last       <= 1'b0;
      fill_err       <= 1'b0;
    end else begin
      mem_data_valid <= beat;
      // LAST is entered with the final word; the pulse lands one cycle later
      mem_last       <= (state == FILL_LAST);
      if (state == FILL_IDLE && miss) begin
        line_base <= {miss_addr[ADDR_W-1:LINE_LG2], {LINE_LG2{1'b0}}};
        count     <= '0;
        fill_err  <= 1'b0;
      end
      if (beat) begin
        mem_addr    <= line_base + beat_ofs;
        mem_data_in <= rdata;
        count       <= count + 1'b1;
        // The beat count, not rlast, frames the burst; a misplaced or
        // missing rlast is only reported.
        if (rresp != AXI_RESP_OKAY || rlast != final_beat) fill_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_line_fill.sv
module tb_axi_line_fill;
  import axi_line_fill_pkg::*;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        miss = 1'b0;
  logic [31:0] miss_addr = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid;
  logic        mem_last;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        fill_err;

  always #5 clk = ~clk;

  axi_line_fill #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(N)) dut (
    .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
    .mem_data_valid(mem_data_valid), .mem_last(mem_last),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .fill_err(fill_err)
  );

  // Per-fill slave configuration
  logic [31:0] words [N];
  logic [1:0]  resp_cfg [N];
  logic        last_cfg [N];
  bit          cont_rv = 0;
  bit          early_rv = 0;
  int          ar_delay = 0;

  // Handshake tracking at the active edge
  int          cyc = 0;
  int          hs_cnt = N;
  int          n_ar = 0;
  int          ar_cyc = 0;
  bit          fill_active = 0;
  bit          hs_last = 0;
  logic [31:0] ar_addr_rec = '0;
  logic [7:0]  ar_len_rec = '0;
  logic [2:0]  ar_size_rec = '0;
  logic [1:0]  ar_burst_rec = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      fill_active <= 0;
      hs_last     <= 0;
      hs_cnt      <= N;
    end else begin
      hs_last <= rvalid && rready;
      if (arvalid && arready) begin
        fill_active  <= 1;
        hs_cnt       <= 0;
        ar_cyc       <= cyc;
        n_ar         <= n_ar + 1;
        ar_addr_rec  <= araddr;
        ar_len_rec   <= arlen;
        ar_size_rec  <= arsize;
        ar_burst_rec <= arburst;
      end
      if (rvalid && rready) begin
        hs_cnt <= hs_cnt + 1;
        if (hs_cnt == N - 1) fill_active <= 0;
      end
    end
  end

  // Output observation away from the active edge
  logic [31:0] vq_addr [$];
  logic [31:0] vq_data [$];
  bit          vq_err [$];
  int          vq_cyc [$];
  int          last_q [$];
  int          consec = 0;
  int          hold_err = 0;
  int          ar_unstable = 0;
  bit          rr_hist [8192];
  logic        prev_mdv = 0;
  logic        prev_arv = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic [31:0] prev_araddr = '0;
  logic [7:0]  prev_arlen = '0;

  always @(negedge clk) begin
    if (cyc < 8192) rr_hist[cyc] <= rready;
    if (!reset) begin
      if (mem_data_valid) begin
        vq_addr.push_back(mem_addr);
        vq_data.push_back(mem_data_in);
        vq_err.push_back(fill_err);
        vq_cyc.push_back(cyc);
      end
      if (mem_last) last_q.push_back(cyc);
      if (mem_data_valid && prev_mdv) consec <= consec + 1;
      if (!mem_data_valid && (mem_addr !== prev_addr || mem_data_in !== prev_data))
        hold_err <= hold_err + 1;
      if (arvalid && prev_arv && (araddr !== prev_araddr || arlen !== prev_arlen))
        ar_unstable <= ar_unstable + 1;
    end
    prev_mdv    <= mem_data_valid;
    prev_arv    <= arvalid;
    prev_addr   <= mem_addr;
    prev_data   <= mem_data_in;
    prev_araddr <= araddr;
    prev_arlen  <= arlen;
  end

  // AXI slave model
  bit rv_real = 0;
  int ar_wait = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset || !arvalid) begin
        arready = 0;
        ar_wait = 0;
      end else if (ar_wait >= ar_delay) begin
        arready = 1;
      end else begin
        arready = 0;
        ar_wait++;
      end
      if (reset || !fill_active) begin
        rv_real = 0;
        rvalid  = early_rv;
        rdata   = 32'hDEAD_BEEF;
        rresp   = 2'b11;
        rlast   = 1'b1;
      end else if (rv_real && rvalid && !hs_last) begin
        rv_real = 1;
      end else if (cont_rv || $urandom_range(0, 2) != 0) begin
        rv_real = 1;
        rvalid  = 1;
        rdata   = words[hs_cnt];
        rresp   = resp_cfg[hs_cnt];
        rlast   = last_cfg[hs_cnt];
      end else begin
        rv_real = 0;
        rvalid  = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int passed = 0;
  int failed = 0;
  int v0, l0, c0, h0, u0, a0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    v0 = vq_addr.size();
    l0 = last_q.size();
    c0 = consec;
    h0 = hold_err;
    u0 = ar_unstable;
    a0 = n_ar;
  endtask

  task automatic cfg_clean();
    for (int i = 0; i < N; i++) begin
      words[i]    = $urandom;
      resp_cfg[i] = 2'b00;
      last_cfg[i] = (i == N - 1);
    end
  endtask

  // Expected sticky error after beat i: any bad response or misplaced rlast so far
  function automatic bit exp_err(input int i);
    bit e = 0;
    for (int j = 0; j <= i; j++)
      if (resp_cfg[j] != 2'b00 || last_cfg[j] != (j == N - 1)) e = 1;
    return e;
  endfunction

  task automatic start_fill(input string tag, input logic [31:0] addr);
    snap();
    miss_addr = addr;
    miss = 1;
    tick(1);
    chk({tag, "_arvalid"}, arvalid, 1);
    chk({tag, "_err_clear"}, fill_err, 0);
  endtask

  task automatic wait_last(input string tag);
    int k = 0;
    while (last_q.size() == l0 && k < 1000) begin
      tick(1);
      k++;
    end
    if (last_q.size() == l0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_fill(input string tag, input logic [31:0] base);
    int n = vq_addr.size() - v0;
    int ea = 0, ed = 0, ee = 0;
    chk({tag, "_beats"}, n, N);
    for (int i = 0; i < n && i < N; i++) begin
      if (vq_addr[v0 + i] !== base + 4 * i) ea++;
      if (vq_data[v0 + i] !== words[i]) ed++;
      if (vq_err[v0 + i] !== exp_err(i)) ee++;
    end
    chk({tag, "_addr_seq"}, ea, 0);
    chk({tag, "_data_seq"}, ed, 0);
    chk({tag, "_err_seq"}, ee, 0);
    chk({tag, "_last_count"}, last_q.size() - l0, 1);
    if (n >= 1 && last_q.size() > l0)
      chk({tag, "_last_timing"}, last_q[l0], vq_cyc[v0 + n - 1] + 1);
    chk({tag, "_consec_valid"}, consec - c0, 0);
    chk({tag, "_hold"}, hold_err - h0, 0);
    chk({tag, "_ar_stable"}, ar_unstable - u0, 0);
    chk({tag, "_ar_count"}, n_ar - a0, 1);
    chk({tag, "_araddr"}, ar_addr_rec, base);
    chk({tag, "_arlen"}, ar_len_rec, N - 1);
    chk({tag, "_arsize"}, ar_size_rec, 2);
    chk({tag, "_arburst"}, ar_burst_rec, 1);
  endtask

  initial begin
    logic [31:0] addr;
    int k, tog, nv, v1, l1, na1;

    // Reset values
    tick(3);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_mdv", mem_data_valid, 0);
    chk("rst_last", mem_last, 0);
    chk("rst_err", fill_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data_in, 0);
    chk("rst_wstb", mem_wstb, 4'b1111);
    reset = 0;
    tick(2);
    chk("idle_arvalid", arvalid, 0);

    // Directed address, randomly paced slave
    cfg_clean();
    start_fill("a", 32'h0001_2344);
    wait_last("a");
    check_fill("a", 32'h0001_2300);
    miss = 0;
    tick(3);

    // Continuous rvalid with alternating patterns
    cont_rv = 1;
    for (int i = 0; i < N; i++) begin
      words[i] = (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      resp_cfg[i] = 2'b00;
      last_cfg[i] = (i == N - 1);
    end
    addr = $urandom;
    start_fill("b", addr);
    wait_last("b");
    check_fill("b", addr & ~32'h7F);
    tog = 0;
    nv = vq_addr.size() - v0;
    if (nv >= 1) begin
      if (rr_hist[ar_cyc + 1] !== 1'b1) tog++;
      for (int c = ar_cyc + 2; c < vq_cyc[v0 + nv - 1] && c < 8192; c++)
        if (rr_hist[c] === rr_hist[c - 1]) tog++;
    end
    chk("b_rready_toggle", tog, 0);
    cont_rv = 0;
    miss = 0;
    tick(3);

    // Slow arready, early stray rvalid, miss dropped mid-fill
    ar_delay = 5;
    early_rv = 1;
    cfg_clean();
    addr = $urandom;
    start_fill("c", addr);
    tick(3);
    miss = 0;
    wait_last("c");
    check_fill("c", addr & ~32'h7F);
    if (vq_addr.size() > v0) chk("c_no_early_valid", vq_cyc[v0] > ar_cyc, 1);
    ar_delay = 0;
    early_rv = 0;
    tick(3);

    // Error response on beat 7, early rlast on beat 20, then hold miss in DRAIN
    cfg_clean();
    resp_cfg[7] = 2'b10;
    last_cfg[20] = 1'b1;
    addr = $urandom;
    start_fill("d", addr);
    wait_last("d");
    check_fill("d", addr & ~32'h7F);
    chk("d_err_beat6", vq_err[v0 + 6], 0);
    chk("d_err_beat7", vq_err[v0 + 7], 1);
    chk("d_err_beat20", vq_err[v0 + 20], 1);
    chk("d_err_sticky", fill_err, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("drain_no_arvalid", arvalid, 0);
    end
    chk("drain_no_new_ar", n_ar - a0, 1);
    miss = 0;
    tick(1);
    chk("drain_exit_no_ar", arvalid, 0);

    // Missing rlast on the final beat; fill_err must clear at fill start
    cfg_clean();
    last_cfg[N - 1] = 1'b0;
    addr = $urandom;
    start_fill("f", addr);
    wait_last("f");
    check_fill("f", addr & ~32'h7F);
    chk("f_err_beat30", vq_err[v0 + 30], 0);
    chk("f_err_beat31", vq_err[v0 + 31], 1);
    miss = 0;
    tick(3);

    // Reset in the middle of a burst
    cfg_clean();
    resp_cfg[3] = 2'b01;
    addr = $urandom;
    start_fill("g", addr);
    k = 0;
    while (vq_addr.size() - v0 < 10 && k < 500) begin
      tick(1);
      k++;
    end
    if (vq_addr.size() - v0 < 10) chk("g_timeout", 0, 1);
    nv = vq_addr.size() - v0;
    chk("g_err_pre", fill_err, 1);
    chk("g_addr_pre", mem_addr, (addr & ~32'h7F) + 4 * (nv - 1));
    #2 reset = 1;
    #1;
    chk("g_rst_arvalid", arvalid, 0);
    chk("g_rst_rready", rready, 0);
    chk("g_rst_mdv", mem_data_valid, 0);
    chk("g_rst_last", mem_last, 0);
    chk("g_rst_err", fill_err, 0);
    chk("g_rst_addr", mem_addr, 0);
    chk("g_rst_data", mem_data_in, 0);
    chk("g_rst_wstb", mem_wstb, 4'b1111);
    v1 = vq_addr.size();
    l1 = last_q.size();
    na1 = n_ar;
    miss = 0;
    tick(2);
    reset = 0;
    tick(80);
    chk("g_no_valid_after", vq_addr.size() - v1, 0);
    chk("g_no_last_after", last_q.size() - l1, 0);
    chk("g_no_ar_after", n_ar - na1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
